// File: rtl/htax_outport_pkt_mux.sv
// htax_outport_pkt_mux: packet-locking output-port data mux for the HTAX switch (NUM_PORTS inputs).
// Optional even parity on data_out is built only when HTAX_OUTPORT_PARITY_EN is defined.
module htax_outport_pkt_mux #(
    parameter int NUM_PORTS = 4,
    parameter int VC        = 2,
    parameter int WIDTH     = 64,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic [NUM_PORTS-1:0]       inport_sel,
    input  logic                       any_gnt,
    input  logic [WIDTH*NUM_PORTS-1:0] data_in,
    input  logic [VC*NUM_PORTS-1:0]    sot_in,
    input  logic [NUM_PORTS-1:0]       eot_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    output logic [VC-1:0]              sot_out,
    output logic                       eot_out,
    output logic [VC-1:0]              vc_out,
    output logic [CNT_W-1:0]           pkt_len_out,
    output logic [2:0]                 err_out,
    output logic                       data_par_out
);
    // state  | meaning
    // IDLE   | no packet owned; a non-zero grant is accepted
    // ACTIVE | locked onto sel_reg; one beat per cycle until eot or MAX_BEATS
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state, state_nxt;
    logic [NUM_PORTS-1:0]  sel_reg, sel_low;
    logic                  first_beat;
    logic [CNT_W-1:0]      beat_cnt;
    logic [WIDTH-1:0]      data_mux;
    logic [VC-1:0]         sot_mux;
    logic                  eot_sel, active, end_normal, end_forced, sel_onehot;
    logic                  accept, err_busy, err_sel, err_pkt;

    // AND-OR mux keyed by the one-hot sel_reg
    always_comb begin
        data_mux = '0;
        sot_mux  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            data_mux |= data_in[i*WIDTH +: WIDTH] & {WIDTH{sel_reg[i]}};
            sot_mux  |= sot_in[i*VC +: VC] & {VC{sel_reg[i]}};
        end
    end

    assign eot_sel    = |(eot_in & sel_reg);
    assign sel_low    = inport_sel & (~inport_sel + NUM_PORTS'(1));
    assign sel_onehot = (inport_sel != '0) && (sel_low == inport_sel);
    assign active     = (state == ACTIVE);
    assign end_normal = active && eot_sel;
    assign end_forced = active && !eot_sel && (beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign err_pkt    = active && ((first_beat && (sot_mux == '0)) || end_forced);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        err_busy  = 1'b0;
        err_sel   = 1'b0;
        if (end_normal || end_forced) state_nxt = IDLE;
        if (any_gnt) begin
            if (!active || end_normal) begin
                if (inport_sel == '0) begin
                    err_sel = 1'b1;
                end else begin
                    accept    = 1'b1;
                    err_sel   = !sel_onehot;
                    state_nxt = ACTIVE;
                end
            end else begin
                err_busy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sel_reg     <= '0;
            first_beat  <= 1'b0;
            beat_cnt    <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            sot_out     <= '0;
            eot_out     <= 1'b0;
            vc_out      <= '0;
            pkt_len_out <= '0;
            err_out     <= '0;
        end else begin
            err_out <= {err_pkt, err_sel, err_busy};
            if (accept) begin
                sel_reg    <= sel_low;
                first_beat <= 1'b1;
                beat_cnt   <= '0;
            end else if (active) begin
                first_beat <= 1'b0;
                beat_cnt   <= beat_cnt + CNT_W'(1);
            end
            if (active) begin
                data_out  <= data_mux;
                valid_out <= 1'b1;
                sot_out   <= first_beat ? sot_mux : '0;
                if (first_beat) vc_out <= sot_mux;
                eot_out   <= end_normal || end_forced;
                if (end_normal)      pkt_len_out <= beat_cnt + CNT_W'(1);
                else if (end_forced) pkt_len_out <= CNT_W'(MAX_BEATS);
                else                 pkt_len_out <= '0;
            end else begin
                // data_out deliberately holds its last beat
                valid_out   <= 1'b0;
                sot_out     <= '0;
                eot_out     <= 1'b0;
                vc_out      <= '0;
                pkt_len_out <= '0;
            end
        end
    end

`ifdef HTAX_OUTPORT_PARITY_EN
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) data_par_out <= 1'b0;
        else        data_par_out <= active & (^data_mux);
    end
`else
    assign data_par_out = 1'b0;
`endif

endmodule

// File: tb/tb_htax_outport_pkt_mux.sv
// Table-driven bench for htax_outport_pkt_mux (4 ports, VC=2, 64-bit, 16 beats max).
// Parity checks follow HTAX_OUTPORT_PARITY_EN when it is defined for the build.
module tb_htax_outport_pkt_mux;
    localparam int NP = 4;
    localparam int VCW = 2;
    localparam int W = 64;
    localparam int MB = 16;
    localparam int CW = 5;

    logic            clk = 1'b0;
    logic            res_n;
    logic [NP-1:0]   inport_sel;
    logic            any_gnt;
    logic [W*NP-1:0] data_in;
    logic [VCW*NP-1:0] sot_in;
    logic [NP-1:0]   eot_in;
    logic [W-1:0]    data_out;
    logic            valid_out;
    logic [VCW-1:0]  sot_out;
    logic            eot_out;
    logic [VCW-1:0]  vc_out;
    logic [CW-1:0]   pkt_len_out;
    logic [2:0]      err_out;
    logic            data_par_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    htax_outport_pkt_mux #(.NUM_PORTS(NP), .VC(VCW), .WIDTH(W), .MAX_BEATS(MB)) dut (
        .clk(clk), .res_n(res_n), .inport_sel(inport_sel), .any_gnt(any_gnt),
        .data_in(data_in), .sot_in(sot_in), .eot_in(eot_in),
        .data_out(data_out), .valid_out(valid_out), .sot_out(sot_out), .eot_out(eot_out),
        .vc_out(vc_out), .pkt_len_out(pkt_len_out), .err_out(err_out), .data_par_out(data_par_out)
    );

    typedef struct {
        logic        gnt;
        logic [3:0]  sel;
        logic [15:0] tag;
        logic [7:0]  sot;
        logic [3:0]  eot;
        logic        e_valid;
        int          e_port;
        logic [1:0]  e_sot;
        logic        e_eot;
        logic [1:0]  e_vc;
        logic [4:0]  e_len;
        logic [2:0]  e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] mk(input logic [15:0] tag, input int port);
        return {16'hC0DE, 16'(port), 16'h0000, tag};
    endfunction

    function automatic vec_t v(input logic g, input logic [3:0] s, input logic [15:0] tag,
                               input logic [7:0] so, input logic [3:0] eo, input logic ev,
                               input int ep, input logic [1:0] es, input logic ee,
                               input logic [1:0] evc, input logic [4:0] el, input logic [2:0] er);
        vec_t r;
        r.gnt = g; r.sel = s; r.tag = tag; r.sot = so; r.eot = eo;
        r.e_valid = ev; r.e_port = ep; r.e_sot = es; r.e_eot = ee;
        r.e_vc = evc; r.e_len = el; r.e_err = er;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic g, input logic [3:0] s, input logic [15:0] tag,
                         input logic [7:0] so, input logic [3:0] eo);
        any_gnt = g;
        inport_sel = s;
        for (int i = 0; i < NP; i++) data_in[i*W +: W] = mk(tag, i);
        sot_in = so;
        eot_in = eo;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string n, input logic ev, input int ep, input logic [63:0] ed,
                           input logic [1:0] es, input logic ee, input logic [1:0] evc,
                           input logic [4:0] el, input logic [2:0] er);
        logic epar;
        chk({n, ".valid"}, 64'(valid_out), 64'(ev));
        chk({n, ".sot"}, 64'(sot_out), 64'(es));
        chk({n, ".eot"}, 64'(eot_out), 64'(ee));
        chk({n, ".vc"}, 64'(vc_out), 64'(evc));
        chk({n, ".len"}, 64'(pkt_len_out), 64'(el));
        chk({n, ".err"}, 64'(err_out), 64'(er));
        epar = 1'b0;
        if (ep >= 0) begin
            chk({n, ".data"}, data_out, ed);
`ifdef HTAX_OUTPORT_PARITY_EN
            epar = ev & (^ed);
`endif
        end
        chk({n, ".par"}, 64'(data_par_out), 64'(epar));
    endtask

    initial begin
        // basic 4-beat packet on port 2, distractors on port 0
        vecs.push_back(v(1, 4'b0100, 16'd0,  8'h00, 4'b0000, 0, -1, 2'b00, 0, 2'b00, 5'd0, 3'b000));
        vecs.push_back(v(0, 4'b0000, 16'd1,  8'h10, 4'b0000, 1,  2, 2'b01, 0, 2'b01, 5'd0, 3'b000));
        vecs.push_back(v(0, 4'b0000, 16'd2,  8'h01, 4'b0001, 1,  2, 2'b00, 0, 2'b01, 5'd0, 3'b000));
        vecs.push_back(v(0, 4'b0000, 16'd3,  8'h00, 4'b0000, 1,  2, 2'b00, 0, 2'b01, 5'd0, 3'b000));
        vecs.push_back(v(0, 4'b0000, 16'd4,  8'h00, 4'b0100, 1,  2, 2'b00, 1, 2'b01, 5'd4, 3'b000));
        // back-to-back: port 1 granted in port 2's eot cycle, single-beat port 1 packet
        vecs.push_back(v(1, 4'b0100, 16'd5,  8'h00, 4'b0000, 0, -1, 2'b00, 0, 2'b00, 5'd0, 3'b000));
        vecs.push_back(v(0, 4'b0000, 16'd6,  8'h20, 4'b0000, 1,  2, 2'b10, 0, 2'b10, 5'd0, 3'b000));
        vecs.push_back(v(1, 4'b0010, 16'd7,  8'h00, 4'b0100, 1,  2, 2'b00, 1, 2'b10, 5'd2, 3'b000));
        vecs.push_back(v(0, 4'b0000, 16'd8,  8'h04, 4'b0010, 1,  1, 2'b01, 1, 2'b01, 5'd1, 3'b000));
        vecs.push_back(v(0, 4'b0000, 16'd9,  8'h00, 4'b0000, 0, -1, 2'b00, 0, 2'b00, 5'd0, 3'b000));
        // grant while busy
        vecs.push_back(v(1, 4'b0001, 16'd10, 8'h00, 4'b0000, 0, -1, 2'b00, 0, 2'b00, 5'd0, 3'b000));
        vecs.push_back(v(0, 4'b0000, 16'd11, 8'h02, 4'b0000, 1,  0, 2'b10, 0, 2'b10, 5'd0, 3'b000));
        vecs.push_back(v(1, 4'b1000, 16'd12, 8'h00, 4'b0000, 1,  0, 2'b00, 0, 2'b10, 5'd0, 3'b001));
        vecs.push_back(v(0, 4'b0000, 16'd13, 8'h00, 4'b0000, 1,  0, 2'b00, 0, 2'b10, 5'd0, 3'b000));
        vecs.push_back(v(0, 4'b0000, 16'd14, 8'h00, 4'b0001, 1,  0, 2'b00, 1, 2'b10, 5'd4, 3'b000));
        vecs.push_back(v(0, 4'b0000, 16'd15, 8'h00, 4'b0000, 0, -1, 2'b00, 0, 2'b00, 5'd0, 3'b000));
        // non-one-hot grant selects lowest port
        vecs.push_back(v(1, 4'b0110, 16'd16, 8'h00, 4'b0000, 0, -1, 2'b00, 0, 2'b00, 5'd0, 3'b010));
        vecs.push_back(v(0, 4'b0000, 16'd17, 8'h08, 4'b0010, 1,  1, 2'b10, 1, 2'b10, 5'd1, 3'b000));
        vecs.push_back(v(0, 4'b0000, 16'd18, 8'h00, 4'b0000, 0, -1, 2'b00, 0, 2'b00, 5'd0, 3'b000));
        // all-zero grant ignored
        vecs.push_back(v(1, 4'b0000, 16'd19, 8'h00, 4'b0000, 0, -1, 2'b00, 0, 2'b00, 5'd0, 3'b010));
        vecs.push_back(v(0, 4'b0000, 16'd20, 8'hFF, 4'b1111, 0, -1, 2'b00, 0, 2'b00, 5'd0, 3'b000));
        // missing sot on first beat
        vecs.push_back(v(1, 4'b1000, 16'd21, 8'h00, 4'b0000, 0, -1, 2'b00, 0, 2'b00, 5'd0, 3'b000));
        vecs.push_back(v(0, 4'b0000, 16'd22, 8'h01, 4'b0000, 1,  3, 2'b00, 0, 2'b00, 5'd0, 3'b100));
        vecs.push_back(v(0, 4'b0000, 16'd23, 8'h00, 4'b1000, 1,  3, 2'b00, 1, 2'b00, 5'd2, 3'b000));
        vecs.push_back(v(0, 4'b0000, 16'd24, 8'h00, 4'b0000, 0, -1, 2'b00, 0, 2'b00, 5'd0, 3'b000));

        res_n = 1'b0;
        drive(0, 4'b0000, 16'd0, 8'h00, 4'b0000);
        #12;
        chk_out("reset", 0, -1, 64'h0, 2'b00, 0, 2'b00, 5'd0, 3'b000);
        chk("reset.data", data_out, 64'h0);
        @(negedge clk);
        res_n = 1'b1;
        step();

        foreach (vecs[k]) begin
            drive(vecs[k].gnt, vecs[k].sel, vecs[k].tag, vecs[k].sot, vecs[k].eot);
            step();
            chk_out($sformatf("r%0d", k), vecs[k].e_valid, vecs[k].e_port,
                    mk(vecs[k].tag, vecs[k].e_port), vecs[k].e_sot, vecs[k].e_eot,
                    vecs[k].e_vc, vecs[k].e_len, vecs[k].e_err);
        end

        // over-length packet: 20 beats, no eot, forced end at beat 16
        drive(1, 4'b0010, 16'd100, 8'h00, 4'b0000);
        step();
        chk_out("force.gnt", 0, -1, 64'h0, 2'b00, 0, 2'b00, 5'd0, 3'b000);
        for (int b = 1; b <= 20; b++) begin
            drive(0, 4'b0000, 16'(100 + b), (b == 1) ? 8'h04 : 8'h00, 4'b0000);
            step();
            chk_out($sformatf("force.b%0d", b), b <= MB, (b <= MB) ? 1 : -1, mk(16'(100 + b), 1),
                    (b == 1) ? 2'b01 : 2'b00, b == MB, (b <= MB) ? 2'b01 : 2'b00,
                    (b == MB) ? 5'd16 : 5'd0, (b == MB) ? 3'b100 : 3'b000);
        end

        // reset in the middle of a packet
        drive(1, 4'b0001, 16'd200, 8'h00, 4'b0000);
        step();
        for (int b = 1; b <= 2; b++) begin
            drive(0, 4'b0000, 16'd0, (b == 1) ? 8'h01 : 8'h00, 4'b0000);
            data_in[W-1:0] = 64'h1;
            step();
            chk_out($sformatf("rst.b%0d", b), 1, 0, 64'h1, (b == 1) ? 2'b01 : 2'b00, 0, 2'b01,
                    5'd0, 3'b000);
        end
        #2 res_n = 1'b0;
        #1;
        chk_out("rst.async", 0, -1, 64'h0, 2'b00, 0, 2'b00, 5'd0, 3'b000);
        chk("rst.async.data", data_out, 64'h0);
        #3 res_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(0, 4'b0000, 16'(300 + c), 8'h01, 4'b0001);
            step();
            chk_out($sformatf("rst.after%0d", c), 0, -1, 64'h0, 2'b00, 0, 2'b00, 5'd0, 3'b000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/htax_outport_pkt_mux.md
Name: htax_outport_pkt_mux

Overview:
- Parametrised packet-aware output-port data mux for the HTAX switch; generalises the fixed 4-port output data mux to any NUM_PORTS.
- Takes the arbiter's one-hot grant, locks onto the granted input port for one whole packet, and forwards data/sot/eot through one registered stage.
- Tracks the packet VC and beat count.
- Flags protocol errors (grant while busy, non-one-hot grant, missing SOT, over-length packet).

Parameters:
- NUM_PORTS, 4, number of input ports (>=2)
- VC, 2, virtual channels; width of sot and vc signals
- WIDTH, 64, data beat width
- MAX_BEATS, 16, maximum beats per packet, including SOT and EOT beats (>=2)
- CNT_W, $clog2(MAX_BEATS+1), beat counter width

Ports:
- clk  in  1  clock
- res_n  in  1  reset, asynchronous assert, active-low
- inport_sel  in  NUM_PORTS  arbiter grant vector; one-hot expected
- any_gnt  in  1  grant strobe; inport_sel is meaningful only when this is 1
- data_in  in  WIDTH*NUM_PORTS  input data; port i occupies [i*WIDTH +: WIDTH]
- sot_in  in  VC*NUM_PORTS  per-port one-hot VC start-of-transfer
- eot_in  in  NUM_PORTS  per-port end-of-transfer
- data_out  out  WIDTH  forwarded beat
- valid_out  out  1  data_out holds a packet beat
- sot_out  out  VC  VC of the first beat; zero otherwise
- eot_out  out  1  last beat of the packet
- vc_out  out  VC  VC of the current packet, held from first beat to eot
- pkt_len_out  out  CNT_W  beat count; valid only while eot_out=1, else 0
- err_out  out  3  one-cycle error pulses; bit meanings under Behaviour
- data_par_out  out  1  even parity of data_out (optional feature)

Behaviour:
- Clock and reset: one clock, clk. res_n is asynchronous and active-low; all flops clear immediately on assertion.
- Reset values: all outputs 0, FSM in IDLE, sel_reg=0, beat_cnt=0.
- Reset mid-packet: packet abandoned; no eot_out is produced after release.
- FSM states: IDLE and ACTIVE.
- Grant acceptance:
  - In IDLE, any_gnt=1 is accepted.
  - In ACTIVE, any_gnt=1 is accepted only in the cycle where the selected port's eot_in=1 (back-to-back packets).
  - Otherwise it is ignored and err_out[0] pulses next cycle.
- On acceptance:
  - sel_reg <= lowest set bit of inport_sel. Generic AND-OR/priority logic; no fixed-width casex.
  - If inport_sel is not one-hot, err_out[1] pulses.
  - If inport_sel is all zero, the grant is ignored and err_out[1] pulses.
  - Next state ACTIVE; first_beat <= 1; beat_cnt <= 0.
- Timing: grant in cycle t. First beat sampled from port sel_reg in t+1. Output appears in t+2. Steady state is one beat per cycle.
- In each ACTIVE cycle, the block samples port p = sel_reg:
  - data_out <= data_in slice p.
  - valid_out <= 1.
  - beat_cnt <= beat_cnt+1.
- First beat:
  - sot_out <= sot_in slice p; vc_out <= same.
  - If that slice is zero, err_out[2] pulses and vc_out <= 0.
- Later beats: sot_out <= 0.
- Normal end: eot_in[p]=1 gives eot_out <= 1 and pkt_len_out <= beat_cnt+1. Next state is IDLE, unless a grant is accepted in that same cycle.
- Forced end: if beat_cnt+1 == MAX_BEATS and eot_in[p]=0:
  - Forced eot_out=1, pkt_len_out=MAX_BEATS, err_out[2] pulses.
  - Next state IDLE; further beats from that port are dropped.
- Single-beat packet: sot and eot on the same beat gives sot_out!=0, eot_out=1, pkt_len_out=1.
- IDLE output cycle: valid_out=0, sot_out=0, eot_out=0. data_out holds its last value. vc_out is cleared after eot.
- Unselected ports' sot_in and eot_in are ignored.

Optional Feature:
- Macro: HTAX_OUTPORT_PARITY_EN.
- Defined: data_par_out <= ^(data_in slice p), registered alongside data_out. It is 0 whenever valid_out=0.
- Undefined: data_par_out is tied to 0 and no parity logic is built.

Test Plan:
(NUM_PORTS=4, VC=2, WIDTH=64, MAX_BEATS=16 unless stated.)
1. Grant port 2 (sel=4'b0100) at t. Port 2 sends 4 beats, D0..D3, sot=2'b01 on D0, eot on D3. Required: valid_out t+2..t+5; sot_out=01 at t+2 only; vc_out=01 at t+2..t+5; eot_out and pkt_len_out=4 at t+5; err_out=0.
2. Back-to-back: grant port 1 in port 2's eot cycle. Required: port 1's first beat is output the cycle after port 2's eot_out, with no bubble.
3. Grant port 3 while port 0's packet is mid-transfer. Required: err_out[0] pulses once; port 0's packet completes unchanged.
4. Grant sel=4'b0110. Required: port 1 selected; err_out[1] pulses.
5. 20-beat packet with no eot. Required: forced eot_out at beat 16, pkt_len_out=16, err_out[2]=1; valid_out=0 afterwards until the next grant.
6. Assert res_n=0 at beat 2 of a packet. Required: all outputs 0 immediately. After release with no grant, no eot_out and valid_out=0. With HTAX_OUTPORT_PARITY_EN and D=64'h1, data_par_out=1 during that beat.
